// File: rtl/branch_seq_ctrl_pkg.sv
// Shared definitions for the branch sequencer: opcodes, FSM states, width defaults.
package branch_seq_ctrl_pkg;

    localparam int unsigned AW_DEFAULT = 32;
    localparam int unsigned OP_W       = 3;
    localparam int unsigned RS_W       = 32;

    localparam logic [OP_W-1:0] OP_BR   = 3'b000;
    localparam logic [OP_W-1:0] OP_BMI  = 3'b001;
    localparam logic [OP_W-1:0] OP_BPL  = 3'b010;
    localparam logic [OP_W-1:0] OP_BZ   = 3'b011;
    localparam logic [OP_W-1:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_EVAL = 2'd1,
        ST_HALT = 2'd2
    } seq_state_e;

    // Conditional-branch opcodes occupy 000..011.
    function automatic logic is_cond_op(input logic [OP_W-1:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Registered branch-condition evaluator: samples op/rs_val when en is high.
module branch_cond_eval
    import branch_seq_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [OP_W-1:0] op,
    input  logic [RS_W-1:0] rs_val,
    output logic            taken
);

    // Capture the resolved condition on the request edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken <= 1'b0;
        end else if (en) begin
            case (op)
                OP_BR:   taken <= 1'b1;
                OP_BMI:  taken <= rs_val[RS_W-1];
                OP_BPL:  taken <= ~rs_val[RS_W-1] & (|rs_val);
                OP_BZ:   taken <= ~(|rs_val);
                default: taken <= 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/branch_seq_ctrl.sv
// Execute-stage PC sequencer with two-cycle branch resolve and HALT.
// Optional macro BRANCH_STATS_EN adds saturating taken/resolved counters.
module branch_seq_ctrl
    import branch_seq_ctrl_pkg::*;
#(
    parameter int unsigned    AW       = AW_DEFAULT,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_valid,
    input  logic [OP_W-1:0] br_op,
    input  logic [RS_W-1:0] rs_val,
    input  logic [AW-1:0]   br_target,
    output logic [AW-1:0]   pc,
    output logic            busy,
    output logic            flush,
    output logic            taken,
    output logic            halted
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     taken_cnt,
    output logic [31:0]     resolved_cnt
`endif
);

    seq_state_e    state;
    logic [AW-1:0] target_q;
    logic          eval_en;
    logic          cond_taken;

    // Evaluator samples only on an accepted conditional-branch request.
    assign eval_en = (state == ST_RUN) && !stall && br_valid && is_cond_op(br_op);

    branch_cond_eval u_cond (
        .clk    (clk),
        .rst    (rst),
        .en     (eval_en),
        .op     (br_op),
        .rs_val (rs_val),
        .taken  (cond_taken)
    );

    // Sequencer FSM with registered PC and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            pc       <= RESET_PC;
            target_q <= '0;
            busy     <= 1'b0;
            flush    <= 1'b0;
            taken    <= 1'b0;
            halted   <= 1'b0;
        end else begin
            flush <= 1'b0;
            taken <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (!stall) begin
                        if (br_valid && is_cond_op(br_op)) begin
                            target_q <= br_target;
                            busy     <= 1'b1;
                            state    <= ST_EVAL;
                        end else if (br_valid && (br_op == OP_HALT)) begin
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end else begin
                            pc <= pc + AW'(1);
                        end
                    end
                end
                ST_EVAL: begin
                    if (!stall) begin
                        busy  <= 1'b0;
                        state <= ST_RUN;
                        if (cond_taken) begin
                            pc    <= target_q;
                            flush <= 1'b1;
                            taken <= 1'b1;
                        end else begin
                            pc <= pc + AW'(1);
                        end
                    end
                end
                ST_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating resolve statistics, counted on each EVAL exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt    <= '0;
            resolved_cnt <= '0;
        end else if ((state == ST_EVAL) && !stall) begin
            if (resolved_cnt != 32'hFFFF_FFFF) begin
                resolved_cnt <= resolved_cnt + 32'd1;
            end
            if (cond_taken && (taken_cnt != 32'hFFFF_FFFF)) begin
                taken_cnt <= taken_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Randomized bench for branch_seq_ctrl against a transaction-level reference model.
module tb_branch_seq_ctrl;

    localparam int unsigned AW      = 32;
    localparam logic [31:0] RST_PC  = 32'h0;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [2:0]  br_op = 3'b000;
    logic [31:0] rs_val = '0;
    logic [31:0] br_target = '0;
    logic        zero = 1'b0;

    logic [31:0] pc, w_pc;
    logic        busy, flush, taken, halted;
    logic        w_busy, w_flush, w_taken, w_halted;
`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt, resolved_cnt, w_tcnt, w_rcnt;
`endif

    branch_seq_ctrl #(.AW(AW), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_op(br_op),
        .rs_val(rs_val), .br_target(br_target), .pc(pc), .busy(busy),
        .flush(flush), .taken(taken), .halted(halted)
`ifdef BRANCH_STATS_EN
        , .taken_cnt(taken_cnt), .resolved_cnt(resolved_cnt)
`endif
    );

    // Second instance idles from near the top of the address space to show wrap.
    branch_seq_ctrl #(.AW(AW), .RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .rst(rst), .stall(zero), .br_valid(zero), .br_op(br_op),
        .rs_val(rs_val), .br_target(br_target), .pc(w_pc), .busy(w_busy),
        .flush(w_flush), .taken(w_taken), .halted(w_halted)
`ifdef BRANCH_STATS_EN
        , .taken_cnt(w_tcnt), .resolved_cnt(w_rcnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a pending branch carries its outcome decided at request time.
    logic [31:0] m_pc, m_wpc, m_tgt;
    bit          m_pending, m_halted, m_take, m_flush;
    longint      m_tcnt, m_rcnt;

    function automatic bit rule_taken(input logic [2:0] op, input logic [31:0] v);
        int signed sv;
        sv = $signed(v);
        if (op == 3'd0) return 1'b1;
        if (op == 3'd1) return sv < 0;
        if (op == 3'd2) return sv > 0;
        return v == 32'd0;
    endfunction

    task automatic model_step();
        m_wpc = rst ? WRAP_PC : m_wpc + 32'd1;
        m_flush = 1'b0;
        if (rst) begin
            m_pc = RST_PC; m_pending = 0; m_halted = 0; m_tcnt = 0; m_rcnt = 0;
        end else if (m_halted || stall) begin
            // frozen
        end else if (m_pending) begin
            m_pending = 0;
            if (m_rcnt < 64'hFFFF_FFFF) m_rcnt++;
            if (m_take) begin
                m_pc = m_tgt; m_flush = 1'b1;
                if (m_tcnt < 64'hFFFF_FFFF) m_tcnt++;
            end else begin
                m_pc = m_pc + 32'd1;
            end
        end else if (br_valid && br_op <= 3'd3) begin
            m_pending = 1; m_tgt = br_target; m_take = rule_taken(br_op, rs_val);
        end else if (br_valid && br_op == 3'd7) begin
            m_halted = 1;
        end else begin
            m_pc = m_pc + 32'd1;
        end
    endtask

    task automatic check_all();
        chk("pc", 64'(pc), 64'(m_pc));
        chk("busy", 64'(busy), 64'(m_pending));
        chk("flush", 64'(flush), 64'(m_flush));
        chk("taken", 64'(taken), 64'(m_flush));
        chk("halted", 64'(halted), 64'(m_halted));
        chk("wrap_pc", 64'(w_pc), 64'(m_wpc));
        chk("wrap_idle", 64'({w_busy, w_flush, w_taken, w_halted}), 64'd0);
`ifdef BRANCH_STATS_EN
        chk("taken_cnt", 64'(taken_cnt), 64'(m_tcnt));
        chk("resolved_cnt", 64'(resolved_cnt), 64'(m_rcnt));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input bit r, input bit st, input bit v, input logic [2:0] op,
                         input logic [31:0] rs, input logic [31:0] tgt);
        rst = r; stall = st; br_valid = v; br_op = op; rs_val = rs; br_target = tgt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 3'd0, '0, '0);
            step();
        end
    endtask

    task automatic reset_to(input int n);
        drive(1, 0, 0, 3'd0, '0, '0);
        step();
        idle(n);
    endtask

    // One conditional branch with idle resolve cycle.
    task automatic branch(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] tgt);
        drive(0, 0, 1, op, rs, tgt);
        step();
        idle(1);
    endtask

    initial begin
        m_pc = '0; m_wpc = '0; m_tgt = '0; m_pending = 0; m_halted = 0;
        m_take = 0; m_flush = 0; m_tcnt = 0; m_rcnt = 0;

        // Reset, idle counting and wrap
        reset_to(0);
        chk("reset_pc", 64'(pc), 64'd0);
        idle(5);
        chk("idle_pc5", 64'(pc), 64'd5);
        idle(5);

        // BZ taken from pc=10
        drive(0, 0, 1, 3'b011, 32'd0, 32'h40);
        step();
        chk("bz_busy", 64'(busy), 64'd1);
        chk("bz_hold_pc", 64'(pc), 64'd10);
        idle(1);
        chk("bz_pc", 64'(pc), 64'h40);
        chk("bz_flush", 64'(flush), 64'd1);
        idle(1);
        chk("bz_flush_drop", 64'(flush), 64'd0);

        // BMI / BPL not taken, BPL taken
        reset_to(10);
        branch(3'b001, 32'd5, 32'h80);
        chk("bmi_nt_pc", 64'(pc), 64'd11);
        chk("bmi_nt_flush", 64'(flush), 64'd0);
        branch(3'b010, 32'd0, 32'h80);
        chk("bpl0_nt_pc", 64'(pc), 64'd12);
        branch(3'b010, 32'd5, 32'h80);
        chk("bpl5_pc", 64'(pc), 64'h80);
        chk("bpl5_taken", 64'(taken), 64'd1);

        // BR with 3 stall cycles during EVAL
        drive(0, 0, 1, 3'b000, 32'd0, 32'h123);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 3'd0, '0, '0);
            step();
            chk("br_stall_busy", 64'(busy), 64'd1);
            chk("br_stall_pc", 64'(pc), 64'h80);
        end
        idle(1);
        chk("br_pc", 64'(pc), 64'h123);
        chk("br_flush", 64'(flush), 64'd1);

        // HALT at pc=7, then stimulus that must be ignored
        reset_to(7);
        drive(0, 0, 1, 3'b111, '0, '0);
        step();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom);
            step();
        end
        chk("halt_pc", 64'(pc), 64'd7);
        chk("halt_flag", 64'(halted), 64'd1);
        reset_to(0);
        chk("halt_exit", 64'(halted), 64'd0);

        // Reset during EVAL aborts the branch
        drive(0, 0, 1, 3'b000, '0, 32'h55);
        step();
        reset_to(0);
        chk("abort_pc", 64'(pc), 64'd0);

        // Three taken, two not taken for statistics
        reset_to(1);
        branch(3'b000, 32'd1, 32'h10);
        branch(3'b011, 32'd0, 32'h20);
        branch(3'b001, 32'h8000_0000, 32'h30);
        branch(3'b011, 32'd9, 32'h40);
        branch(3'b001, 32'd9, 32'h50);
`ifdef BRANCH_STATS_EN
        chk("stats_taken", 64'(taken_cnt), 64'd3);
        chk("stats_resolved", 64'(resolved_cnt), 64'd5);
`endif

        // Reserved opcode behaves as fall-through
        branch(3'b100, 32'd0, 32'h99);
        chk("reserved_no_busy", 64'(busy), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rs;
            case ($urandom_range(0, 3))
                0: rs = 32'd0;
                1: rs = 32'h8000_0000 | $urandom;
                default: rs = $urandom;
            endcase
            drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 15) == 0) ? 3'b111 : 3'($urandom_range(0, 6)),
                  rs, $urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
